// File: rtl/time_display_scan.sv
// ---------------------------------------------------------------------------
// time_display_scan
//
// Multiplexed four-digit common-anode seven-segment driver. It takes the
// packed BCD game-time word and scans it across the display one digit per
// slot. A snapshot of the time word is taken once per frame, so all four
// digits of a frame come from the same value and the display never tears.
// Digit 2 lights the minutes/seconds separator. Nibbles that are not valid
// BCD (10..15) are shown as a dash.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//    When defined, the digit 3 slot is left dark if the leading nibble of the
//    snapshot is zero. The slot still lasts its full length, so frame timing
//    does not change.
//
// Parameters
//    SCAN_DIV    clock cycles per digit slot (2 or more)
//
// Ports
//    clk         system clock, rising edge
//    reset       asynchronous, active-high reset; blanks the display
//    time_value  packed BCD time word, nibble k drives digit k (0 = rightmost)
//    an_n        digit enables, active-low, bit k = digit k
//    seg_n       segments {g,f,e,d,c,b,a}, active-low
//    dp_n        decimal point / separator, active-low
// ---------------------------------------------------------------------------
module time_display_scan #(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] time_value,
   output logic [3:0]  an_n,
   output logic [6:0]  seg_n,
   output logic        dp_n
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

   // Segment patterns, active-low, ordered {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_DARK = 7'h7F;
   localparam logic [6:0] SEG_DASH = 7'h3F;

   // Scan state
   logic [CW-1:0] div_cnt_q, div_cnt_d;
   logic [1:0]    dig_q,     dig_d;
   logic [15:0]   snap_q,    snap_d;

   // Registered display outputs
   logic [3:0]    an_q,      an_d;
   logic [6:0]    seg_q,     seg_d;
   logic          dp_q,      dp_d;

   logic          slot_tick;
   logic [3:0]    nibble;
   logic [6:0]    seg_digit;

   // Prescaler, digit index and frame snapshot.
   // The snapshot is taken on the tick that leaves digit 3, so the new value
   // is in place exactly when digit 0 of the next frame begins.
   always_comb begin
      slot_tick = (div_cnt_q == DIV_LAST);
      div_cnt_d = div_cnt_q;
      dig_d     = dig_q;
      snap_d    = snap_q;

      if (slot_tick) begin
         div_cnt_d = '0;
         dig_d     = dig_q + 2'd1;
         if (dig_q == 2'd3) begin
            snap_d = time_value;
         end
      end else begin
         div_cnt_d = div_cnt_q + CW'(1);
      end
   end

   // BCD to seven-segment decode of the nibble for the current digit.
   // Anything outside 0..9 is shown as a dash so bad upstream data is
   // visible rather than garbled.
   always_comb begin
      nibble    = snap_q[{dig_q, 2'b00} +: 4];
      seg_digit = SEG_DASH;
      case (nibble)
         4'd0:    seg_digit = 7'h40;
         4'd1:    seg_digit = 7'h79;
         4'd2:    seg_digit = 7'h24;
         4'd3:    seg_digit = 7'h30;
         4'd4:    seg_digit = 7'h19;
         4'd5:    seg_digit = 7'h12;
         4'd6:    seg_digit = 7'h02;
         4'd7:    seg_digit = 7'h78;
         4'd8:    seg_digit = 7'h00;
         4'd9:    seg_digit = 7'h10;
         default: seg_digit = SEG_DASH;
      endcase
   end

   // Next values for the output registers. They follow the registered
   // digit index and snapshot, so the pins change one cycle after dig does.
   always_comb begin
      an_d  = ~(4'b0001 << dig_q);
      seg_d = seg_digit;
      dp_d  = (dig_q != 2'd2);

`ifdef LEADING_ZERO_BLANK_EN
      // Leading-zero blanking only ever applies to the most significant
      // digit; the slot keeps its length, only the light is withheld.
      if ((dig_q == 2'd3) && (snap_q[15:12] == 4'd0)) begin
         an_d  = 4'b1111;
         seg_d = SEG_DARK;
      end
`else
      // Every digit is always shown, including a leading zero.
`endif
   end

   // State and output registers. Reset blanks the display immediately and
   // restarts the scan at digit 0 with an all-zero snapshot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt_q <= '0;
         dig_q     <= 2'd0;
         snap_q    <= 16'h0000;
         an_q      <= 4'b1111;
         seg_q     <= SEG_DARK;
         dp_q      <= 1'b1;
      end else begin
         div_cnt_q <= div_cnt_d;
         dig_q     <= dig_d;
         snap_q    <= snap_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
      end
   end

   assign an_n  = an_q;
   assign seg_n = seg_q;
   assign dp_n  = dp_q;

endmodule

// File: tb/tb_time_display_scan.sv
// ---------------------------------------------------------------------------
// tb_time_display_scan
//
// Drives two copies of the scanner (SCAN_DIV = 4 and SCAN_DIV = 2) from the
// same reset and time word and compares every output on every falling edge
// against a reference model. The model counts clock edges since reset and
// derives the lit digit and the frame snapshot from plain arithmetic on that
// count.
// ---------------------------------------------------------------------------
module tb_time_display_scan;

   localparam int SD_A = 4;
   localparam int SD_B = 2;

   localparam logic [6:0] SEG_TAB [0:9] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] time_value = 16'h0000;

   logic [3:0]  an_a,  an_b;
   logic [6:0]  seg_a, seg_b;
   logic        dp_a,  dp_b;

   int checks = 0;
   int failures = 0;

   // Model state, index 0 = SCAN_DIV 4 instance, index 1 = SCAN_DIV 2
   int          m_edges [2];
   logic [15:0] m_snap  [2];
   logic [3:0]  exp_an  [2];
   logic [6:0]  exp_seg [2];
   logic        exp_dp  [2];
   int          m_sd;
   int          m_dig;

   time_display_scan #(.SCAN_DIV(SD_A)) dut_a (
      .clk(clk), .reset(reset), .time_value(time_value),
      .an_n(an_a), .seg_n(seg_a), .dp_n(dp_a)
   );

   time_display_scan #(.SCAN_DIV(SD_B)) dut_b (
      .clk(clk), .reset(reset), .time_value(time_value),
      .an_n(an_b), .seg_n(seg_b), .dp_n(dp_b)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] segOf(input logic [3:0] n);
      if (n > 4'd9) return 7'h3F;
      return SEG_TAB[n];
   endfunction

   // Reference model: after edge k the pins show the digit that was active
   // after edge k-1, i.e. digit ((k-1)/SD) mod 4. A new snapshot is taken
   // at every edge whose count is a whole number of frames.
   always @(posedge clk or posedge reset) begin
      for (int i = 0; i < 2; i++) begin
         m_sd = (i == 0) ? SD_A : SD_B;
         if (reset) begin
            m_edges[i] = 0;
            m_snap[i]  = 16'h0000;
            exp_an[i]  = 4'b1111;
            exp_seg[i] = 7'h7F;
            exp_dp[i]  = 1'b1;
         end else begin
            m_dig      = (m_edges[i] / m_sd) % 4;
            exp_an[i]  = 4'hF & ~(4'(1 << m_dig));
            exp_seg[i] = segOf(4'((m_snap[i] >> (4 * m_dig)) & 16'hF));
            exp_dp[i]  = (m_dig == 2) ? 1'b0 : 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
            if ((m_dig == 3) && (m_snap[i][15:12] == 4'd0)) begin
               exp_an[i]  = 4'b1111;
               exp_seg[i] = 7'h7F;
            end
`endif
            m_edges[i] = m_edges[i] + 1;
            if ((m_edges[i] % (4 * m_sd)) == 0) begin
               m_snap[i] = time_value;
            end
         end
      end
   end

   task automatic checkVec(input string tag, input logic [15:0] obs,
                           input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkVec({tag, "_an4"},  16'(an_a),  16'(exp_an[0]));
      checkVec({tag, "_seg4"}, 16'(seg_a), 16'(exp_seg[0]));
      checkVec({tag, "_dp4"},  16'(dp_a),  16'(exp_dp[0]));
      checkVec({tag, "_an2"},  16'(an_b),  16'(exp_an[1]));
      checkVec({tag, "_seg2"}, 16'(seg_b), 16'(exp_seg[1]));
      checkVec({tag, "_dp2"},  16'(dp_b),  16'(exp_dp[1]));
   endtask

   task automatic applyStimulus(input string tag, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         checkOutput(tag);
      end
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired before the end of the run");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit found;

      // Reset: display dark
      time_value = 16'h1234;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset");
      checkVec("reset_an_const",  16'(an_a),  16'h000F);
      checkVec("reset_seg_const", 16'(seg_a), 16'h007F);
      checkVec("reset_dp_const",  16'(dp_a),  16'h0001);

      // First edge after release shows digit 0 of the zero snapshot
      reset = 1'b0;
      @(negedge clk);
      checkOutput("first");
      checkVec("first_an_const",  16'(an_a),  16'h000E);
      checkVec("first_seg_const", 16'(seg_a), 16'h0040);

      // 1234 held across a frame boundary, then 5678 changed mid-frame
      applyStimulus("hold1234", 22);
      time_value = 16'h5678;
      applyStimulus("chg5678", 40);

      // Invalid BCD nibbles
      time_value = 16'hAF09;
      applyStimulus("badbcd", 36);

      // Leading zero
      time_value = 16'h0059;
      applyStimulus("lead0", 36);

      // Random time words held for random lengths
      for (int r = 0; r < 25; r++) begin
         time_value = 16'($urandom);
         applyStimulus("rand", int'($urandom_range(1, 24)));
      end

      // Asynchronous reset in the middle of the digit 2 slot
      found = 1'b0;
      for (int w = 0; w < 64 && !found; w++) begin
         @(negedge clk);
         checkOutput("seek_dig2");
         if (exp_an[0] == 4'b1011) found = 1'b1;
      end
      checkVec("seek_dig2_found", 16'(found), 16'h0001);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_reset");
      checkVec("async_an_const",  16'(an_a),  16'h000F);
      checkVec("async_seg_const", 16'(seg_a), 16'h007F);
      @(negedge clk);
      reset = 1'b0;
      time_value = 16'h9876;
      @(negedge clk);
      checkOutput("restart");
      checkVec("restart_an_const",  16'(an_a),  16'h000E);
      checkVec("restart_seg_const", 16'(seg_a), 16'h0040);
      applyStimulus("after_reset", 40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
